// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard control bundle: decode/issue/write-back/jump inputs and stall/flush/status outputs.
// The master side drives the decode and write-back signals; the slave side is hazard_ctrl.
interface hazard_ctrl_if;
   logic        dec_valid_i;
   logic [4:0]  rs1_addr_i;
   logic [4:0]  rs2_addr_i;
   logic        rs1_sel_i;
   logic        rs2_sel_i;
   logic        iss_fire_i;
   logic        iss_load_i;
   logic [4:0]  iss_rd_i;
   logic        wb_we_i;
   logic        wb_load_i;
   logic [4:0]  wb_rd_i;
   logic        jump_i;
   logic        stall_o;
   logic        flush_o;
   logic [31:0] pending_o;
   logic        err_o;

   modport master (
      output dec_valid_i, rs1_addr_i, rs2_addr_i, rs1_sel_i, rs2_sel_i,
      output iss_fire_i, iss_load_i, iss_rd_i, wb_we_i, wb_load_i, wb_rd_i, jump_i,
      input  stall_o, flush_o, pending_o, err_o
   );

   modport slave (
      input  dec_valid_i, rs1_addr_i, rs2_addr_i, rs1_sel_i, rs2_sel_i,
      input  iss_fire_i, iss_load_i, iss_rd_i, wb_we_i, wb_load_i, wb_rd_i, jump_i,
      output stall_o, flush_o, pending_o, err_o
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Decode-stage sequencer: load scoreboard, load-use stall, post-jump flush window, stall watchdog.
// Define HAZARD_PERF_EN to add the perf_stall_o / perf_flush_o event counters.
module hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES  = 1,
   parameter bit          WB_BYPASS     = 1'b1,
   parameter int unsigned STALL_TIMEOUT = 255
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave ctrl
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]  perf_stall_o,
   output logic [31:0]  perf_flush_o
`endif
);

   typedef enum logic [1:0] {StRun, StStall, StFlush} state_e;

   localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);
   localparam logic [7:0] Timeout   = 8'(STALL_TIMEOUT);

   state_e      state_q;
   logic [2:0]  flush_cnt_q;
   logic [7:0]  stall_cnt_q, stall_cnt_d;
   logic        err_q;
   logic [31:0] sb_q, sb_d;
   logic        wb_clr, rs1_busy, rs2_busy, hz, stall, flush;

   assign wb_clr = ctrl.wb_we_i & ctrl.wb_load_i;

   // A load write-back in the same cycle is forwarded by the RF write-through.
   assign rs1_busy = sb_q[ctrl.rs1_addr_i] & (ctrl.rs1_addr_i != 5'd0) &
                     ~(WB_BYPASS & wb_clr & (ctrl.wb_rd_i == ctrl.rs1_addr_i));
   assign rs2_busy = sb_q[ctrl.rs2_addr_i] & (ctrl.rs2_addr_i != 5'd0) &
                     ~(WB_BYPASS & wb_clr & (ctrl.wb_rd_i == ctrl.rs2_addr_i));

   assign hz    = ctrl.dec_valid_i & ((ctrl.rs1_sel_i & rs1_busy) | (ctrl.rs2_sel_i & rs2_busy));
   assign flush = ctrl.jump_i | (state_q == StFlush);
   assign stall = hz & ~flush;

   assign ctrl.stall_o   = stall;
   assign ctrl.flush_o   = flush;
   assign ctrl.pending_o = sb_q;
   assign ctrl.err_o     = err_q;

   // Set is applied after clear so a same-cycle issue of the same rd wins.
   always_comb begin
      sb_d = sb_q;
      if (wb_clr) sb_d[ctrl.wb_rd_i] = 1'b0;
      if (ctrl.iss_fire_i && ctrl.iss_load_i) sb_d[ctrl.iss_rd_i] = 1'b1;
      sb_d[0] = 1'b0;
   end

   always_comb begin
      if (!stall)                    stall_cnt_d = 8'd0;
      else if (stall_cnt_q == 8'hff) stall_cnt_d = 8'hff;
      else                           stall_cnt_d = stall_cnt_q + 8'd1;
   end

   // flush_cnt holds the FLUSH cycles still owed, including the current one.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StRun;
         flush_cnt_q <= 3'd0;
      end else if (ctrl.jump_i) begin
         flush_cnt_q <= FlushLoad;
         state_q     <= (FLUSH_CYCLES > 1) ? StFlush : StRun;
      end else begin
         unique case (state_q)
            StRun:   if (hz) state_q <= StStall;
            StStall: if (!hz) state_q <= StRun;
            StFlush: begin
               flush_cnt_q <= flush_cnt_q - 3'd1;
               if (flush_cnt_q <= 3'd1) state_q <= hz ? StStall : StRun;
            end
            default: state_q <= StRun;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sb_q        <= 32'd0;
         stall_cnt_q <= 8'd0;
         err_q       <= 1'b0;
      end else begin
         sb_q        <= sb_d;
         stall_cnt_q <= stall_cnt_d;
         if ((Timeout != 8'd0) && (stall_cnt_d == Timeout)) err_q <= 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_q, perf_flush_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         perf_stall_q <= 32'd0;
         perf_flush_q <= 32'd0;
      end else begin
         perf_stall_q <= perf_stall_q + {31'd0, stall};
         perf_flush_q <= perf_flush_q + {31'd0, ctrl.jump_i};
      end
   end

   assign perf_stall_o = perf_stall_q;
   assign perf_flush_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle expected outputs from a behavioural model go
// through a queue and are compared against the DUT just before the next rising edge.
module tb_hazard_ctrl;
   localparam int unsigned FC  = 3;
   localparam bit          BYP = 1'b1;
   localparam int unsigned TO  = 4;

   typedef struct {
      string       tag;
      logic        stall;
      logic        flush;
      logic [31:0] pend;
      logic        err;
   } want_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   hazard_ctrl_if ctrl ();

`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall, perf_flush;
`endif

   hazard_ctrl #(
      .FLUSH_CYCLES (FC),
      .WB_BYPASS    (BYP),
      .STALL_TIMEOUT(TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ctrl(ctrl)
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall_o(perf_stall),
      .perf_flush_o(perf_flush)
`endif
   );

   int          checks = 0;
   int          errors = 0;
   want_t       want_q[$];
   logic [31:0] m_sb;
   int          m_flush_left;
   int          m_run;
   logic        m_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      if (obs !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, want);
      end
   endtask

   task automatic idle();
      ctrl.dec_valid_i = 1'b0;
      ctrl.rs1_addr_i  = 5'd0;
      ctrl.rs2_addr_i  = 5'd0;
      ctrl.rs1_sel_i   = 1'b0;
      ctrl.rs2_sel_i   = 1'b0;
      ctrl.iss_fire_i  = 1'b0;
      ctrl.iss_load_i  = 1'b0;
      ctrl.iss_rd_i    = 5'd0;
      ctrl.wb_we_i     = 1'b0;
      ctrl.wb_load_i   = 1'b0;
      ctrl.wb_rd_i     = 5'd0;
      ctrl.jump_i      = 1'b0;
   endtask

   task automatic issue_load(input logic [4:0] rd);
      ctrl.iss_fire_i = 1'b1;
      ctrl.iss_load_i = 1'b1;
      ctrl.iss_rd_i   = rd;
   endtask

   task automatic consume(input logic [4:0] r1, input logic s1, input logic [4:0] r2,
                          input logic s2);
      ctrl.dec_valid_i = 1'b1;
      ctrl.rs1_addr_i  = r1;
      ctrl.rs1_sel_i   = s1;
      ctrl.rs2_addr_i  = r2;
      ctrl.rs2_sel_i   = s2;
   endtask

   task automatic wb(input logic load, input logic [4:0] rd);
      ctrl.wb_we_i   = 1'b1;
      ctrl.wb_load_i = load;
      ctrl.wb_rd_i   = rd;
   endtask

   // Called at a falling edge with inputs already applied; returns at the next falling edge.
   task automatic cyc(input string tag);
      want_t w;
      logic  wbc, b1, b2, hz;
      wbc = ctrl.wb_we_i & ctrl.wb_load_i;
      b1  = m_sb[ctrl.rs1_addr_i] && (ctrl.rs1_addr_i != 0) &&
            !(BYP && wbc && (ctrl.wb_rd_i == ctrl.rs1_addr_i));
      b2  = m_sb[ctrl.rs2_addr_i] && (ctrl.rs2_addr_i != 0) &&
            !(BYP && wbc && (ctrl.wb_rd_i == ctrl.rs2_addr_i));
      hz  = ctrl.dec_valid_i && ((ctrl.rs1_sel_i && b1) || (ctrl.rs2_sel_i && b2));
      w.tag   = tag;
      w.flush = ctrl.jump_i || (m_flush_left > 0);
      w.stall = hz && !w.flush;
      w.pend  = m_sb;
      w.err   = m_err;
      want_q.push_back(w);

      #2;
      w = want_q.pop_front();
      check($sformatf("%s/stall", w.tag), {31'd0, ctrl.stall_o}, {31'd0, w.stall});
      check($sformatf("%s/flush", w.tag), {31'd0, ctrl.flush_o}, {31'd0, w.flush});
      check($sformatf("%s/pending", w.tag), ctrl.pending_o, w.pend);
      check($sformatf("%s/err", w.tag), {31'd0, ctrl.err_o}, {31'd0, w.err});

      @(posedge clk);
      if (!rst) begin
         m_sb = 32'd0; m_flush_left = 0; m_run = 0; m_err = 1'b0;
      end else begin
         if (wbc) m_sb[ctrl.wb_rd_i] = 1'b0;
         if (ctrl.iss_fire_i && ctrl.iss_load_i && ctrl.iss_rd_i != 0) m_sb[ctrl.iss_rd_i] = 1'b1;
         if (ctrl.jump_i) m_flush_left = FC - 1;
         else if (m_flush_left > 0) m_flush_left--;
         if (w.stall) m_run = (m_run < 255) ? m_run + 1 : 255;
         else m_run = 0;
         if (TO != 0 && m_run == TO) m_err = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      idle();
      m_sb = 32'd0; m_flush_left = 0; m_run = 0; m_err = 1'b0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      cyc("reset");
      rst = 1'b1;
      cyc("idle");

      // Load-use on x5, resolved by a bypassed load write-back.
      issue_load(5'd5);                  cyc("ld_x5");
      idle(); consume(5'd5, 1, 5'd0, 0); cyc("use_x5_a");
      cyc("use_x5_b");
      wb(1'b1, 5'd5);                    cyc("use_x5_wb");
      idle();                            cyc("x5_clear");

      // Load to x0 never marks pending or stalls.
      issue_load(5'd0);                  cyc("ld_x0");
      idle(); consume(5'd0, 1, 5'd0, 1); cyc("use_x0");
      idle();                            cyc("x0_idle");

      // Single jump, then a second jump inside the window.
      ctrl.jump_i = 1'b1;                cyc("jmp1");
      ctrl.jump_i = 1'b0;                cyc("jmp1_f1");
      cyc("jmp1_f2");
      cyc("jmp1_end");
      ctrl.jump_i = 1'b1;                cyc("jmp2a");
      ctrl.jump_i = 1'b0;                cyc("jmp2a_f1");
      ctrl.jump_i = 1'b1;                cyc("jmp2b");
      ctrl.jump_i = 1'b0;                cyc("jmp2b_f1");
      cyc("jmp2b_f2");
      cyc("jmp2_end");

      // Jump overrides a stall on x7; scoreboard keeps x7 pending.
      issue_load(5'd7);                  cyc("ld_x7");
      idle(); consume(5'd0, 0, 5'd7, 1); cyc("use_x7");
      ctrl.jump_i = 1'b1;                cyc("jmp_on_stall");
      ctrl.jump_i = 1'b0;                cyc("x7_f1");
      cyc("x7_f2");
      cyc("x7_restall");
      wb(1'b1, 5'd7);                    cyc("x7_wb");
      idle();                            cyc("x7_clear");

      // Issue and write-back of x9 in the same cycle: set wins.
      issue_load(5'd9); wb(1'b1, 5'd9);  cyc("x9_same");
      idle();                            cyc("x9_pend");
      wb(1'b1, 5'd9);                    cyc("x9_wb");
      idle();                            cyc("x9_clear");

      // Watchdog: stall on x3 held with no load write-back.
      issue_load(5'd3);                  cyc("ld_x3");
      idle(); consume(5'd3, 1, 5'd0, 0); cyc("wd_1");
      wb(1'b0, 5'd3);                    cyc("wd_2_nonload_wb");
      ctrl.wb_we_i = 1'b0;               cyc("wd_3");
      cyc("wd_4");
      cyc("wd_5");
      cyc("wd_6");
      wb(1'b1, 5'd3);                    cyc("wd_release");
      idle();                            cyc("wd_sticky");

      // Reset in the middle of a flush window clears flush and the error.
      ctrl.jump_i = 1'b1;                cyc("pre_rst_jmp");
      ctrl.jump_i = 1'b0; rst = 1'b0;    cyc("rst_mid_flush");
      rst = 1'b1;                        cyc("post_rst");
      cyc("post_rst_idle");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
